// File: rtl/ps2_keys_pkg.sv
// Shared PS/2 Set 2 scan-code constants, prefix-FSM state type and the
// decoded key-event payload passed from the prefix FSM to the key map.
package ps2_keys_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] SC_EXT    = 8'hE0;
  localparam logic [BYTE_W-1:0] SC_BRK    = 8'hF0;
  localparam logic [BYTE_W-1:0] SC_A      = 8'h1C;
  localparam logic [BYTE_W-1:0] SC_D      = 8'h23;
  localparam logic [BYTE_W-1:0] SC_SPACE  = 8'h29;
  localparam logic [BYTE_W-1:0] SC_LARROW = 8'h6B;
  localparam logic [BYTE_W-1:0] SC_RARROW = 8'h74;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } prefix_state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] code;
    logic              is_ext;
    logic              is_break;
  } key_event_t;

  function automatic logic is_prefix(input logic [BYTE_W-1:0] b);
    return (b == SC_EXT) || (b == SC_BRK);
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Byte stream from the PS/2 receiver in, registered game-control levels out.
interface ps2_key_decoder_if;
  import ps2_keys_pkg::*;

  logic              ps2_key_pressed;
  logic [BYTE_W-1:0] ps2_out;
  logic              move_left;
  logic              move_right;
  logic              game_status;
  logic [BYTE_W-1:0] last_code;

  modport master (
    output ps2_key_pressed,
    output ps2_out,
    input  move_left,
    input  move_right,
    input  game_status,
    input  last_code
  );

  modport slave (
    input  ps2_key_pressed,
    input  ps2_out,
    output move_left,
    output move_right,
    output game_status,
    output last_code
  );

endinterface

// File: rtl/ps2_prefix_fsm.sv
// Edge-detects incoming bytes, folds E0/F0 prefixes into the following code
// and emits a one-cycle key event; stale prefixes are dropped by a watchdog.
module ps2_prefix_fsm
  import ps2_keys_pkg::*;
#(
  parameter int unsigned PREFIX_TIMEOUT = 1_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              key_pressed_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              code_valid_o,
  output key_event_t        event_o
);

  localparam int unsigned CNT_W = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PREFIX_TIMEOUT);

  logic          kp_q;
  logic [CNT_W-1:0] cnt_q;
  prefix_state_e state_q;
  logic          valid_q;
  key_event_t    evt_q;

  logic          accept_c;
  logic          expire_c;
  prefix_state_e cur_c;

  // An expiring prefix is treated as already gone for a byte arriving that cycle.
  always_comb begin
    accept_c = key_pressed_i & ~kp_q;
    expire_c = (state_q != IDLE) && (cnt_q == CNT_MAX);
    cur_c    = expire_c ? IDLE : state_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      kp_q    <= 1'b0;
      cnt_q   <= '0;
      state_q <= IDLE;
      valid_q <= 1'b0;
      evt_q   <= '0;
    end else begin
      kp_q    <= key_pressed_i;
      valid_q <= 1'b0;
      if (accept_c) begin
        cnt_q <= '0;
        if (is_prefix(byte_i)) begin
          case (cur_c)
            IDLE:    state_q <= (byte_i == SC_EXT) ? EXT : BRK;
            EXT:     state_q <= (byte_i == SC_BRK) ? EXT_BRK : EXT;
            BRK:     state_q <= (byte_i == SC_EXT) ? EXT_BRK : BRK;
            default: state_q <= EXT_BRK;
          endcase
        end else begin
          state_q        <= IDLE;
          valid_q        <= 1'b1;
          evt_q.code     <= byte_i;
          evt_q.is_ext   <= (cur_c == EXT) || (cur_c == EXT_BRK);
          evt_q.is_break <= (cur_c == BRK) || (cur_c == EXT_BRK);
        end
      end else if (expire_c || (state_q == IDLE)) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign code_valid_o = valid_q;
  assign event_o      = evt_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 Set 2 key decoder: held-key tracking and registered move/run levels.
// Optional macro PS2_ARROW_KEYS_EN adds extended arrow keys to left/right.
module ps2_key_decoder
  import ps2_keys_pkg::*;
#(
  parameter int unsigned PREFIX_TIMEOUT = 1_000_000
) (
  input  logic               clock,
  input  logic               reset,
  ps2_key_decoder_if.slave   bus
);

  logic       code_valid;
  key_event_t evt;

  ps2_prefix_fsm #(
    .PREFIX_TIMEOUT (PREFIX_TIMEOUT)
  ) u_prefix_fsm (
    .clock         (clock),
    .reset         (reset),
    .key_pressed_i (bus.ps2_key_pressed),
    .byte_i        (bus.ps2_out),
    .code_valid_o  (code_valid),
    .event_o       (evt)
  );

  logic              hl_q, hl_d;
  logic              hr_q, hr_d;
  logic              hs_q, hs_d;
  logic              gs_q, gs_d;
  logic [BYTE_W-1:0] last_q, last_d;
  logic              ml_q, ml_d;
  logic              mr_q, mr_d;
  logic              left_c, right_c;
`ifdef PS2_ARROW_KEYS_EN
  logic              hl_arrow_q, hl_arrow_d;
  logic              hr_arrow_q, hr_arrow_d;
`endif

  // Key map and held flags; outputs are formed from next-state so they land one cycle after the event.
  always_comb begin
    hl_d   = hl_q;
    hr_d   = hr_q;
    hs_d   = hs_q;
    gs_d   = gs_q;
    last_d = last_q;
`ifdef PS2_ARROW_KEYS_EN
    hl_arrow_d = hl_arrow_q;
    hr_arrow_d = hr_arrow_q;
`endif
    if (code_valid) begin
      last_d = evt.code;
      if (!evt.is_ext) begin
        case (evt.code)
          SC_A: hl_d = ~evt.is_break;
          SC_D: hr_d = ~evt.is_break;
          SC_SPACE: begin
            if (!evt.is_break && !hs_q) gs_d = ~gs_q;
            hs_d = ~evt.is_break;
          end
          default: ;
        endcase
      end
`ifdef PS2_ARROW_KEYS_EN
      else begin
        case (evt.code)
          SC_LARROW: hl_arrow_d = ~evt.is_break;
          SC_RARROW: hr_arrow_d = ~evt.is_break;
          default: ;
        endcase
      end
`endif
    end
`ifdef PS2_ARROW_KEYS_EN
    left_c  = hl_d | hl_arrow_d;
    right_c = hr_d | hr_arrow_d;
`else
    left_c  = hl_d;
    right_c = hr_d;
`endif
    ml_d = left_c & ~right_c;
    mr_d = right_c & ~left_c;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hl_q   <= 1'b0;
      hr_q   <= 1'b0;
      hs_q   <= 1'b0;
      gs_q   <= 1'b0;
      last_q <= '0;
      ml_q   <= 1'b0;
      mr_q   <= 1'b0;
`ifdef PS2_ARROW_KEYS_EN
      hl_arrow_q <= 1'b0;
      hr_arrow_q <= 1'b0;
`endif
    end else begin
      hl_q   <= hl_d;
      hr_q   <= hr_d;
      hs_q   <= hs_d;
      gs_q   <= gs_d;
      last_q <= last_d;
      ml_q   <= ml_d;
      mr_q   <= mr_d;
`ifdef PS2_ARROW_KEYS_EN
      hl_arrow_q <= hl_arrow_d;
      hr_arrow_q <= hr_arrow_d;
`endif
    end
  end

  assign bus.move_left   = ml_q;
  assign bus.move_right  = mr_q;
  assign bus.game_status = gs_q;
  assign bus.last_code   = last_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scenarios plus random byte streams,
// checked every cycle against a prefix-bit/held-key model of the decoder.
module tb_ps2_key_decoder;
  import ps2_keys_pkg::*;

  localparam int T = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;

  ps2_key_decoder_if bus();

  ps2_key_decoder #(.PREFIX_TIMEOUT(T)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit started = 1'b0;

  // Model: pending prefixes as two sticky bits plus held-key flags.
  bit m_ext, m_brk, m_hl, m_hr, m_hs, m_gs, m_hla, m_hra;
  logic [7:0] m_last;
  int m_last_acc;

  bit e_ml, e_mr, e_gs;
  logic [7:0] e_last;
  bit n_ml, n_mr, n_gs;
  logic [7:0] n_last;
  bit sch_valid;
  int sch_at;

  task automatic check1(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, got, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %02h expected %02h", name, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    m_ext = 0; m_brk = 0; m_hl = 0; m_hr = 0; m_hs = 0; m_gs = 0;
    m_hla = 0; m_hra = 0; m_last = 8'h00; m_last_acc = 0;
  endtask

  // Called at the negedge before the accepting posedge (cyc+1).
  task automatic model_accept(input logic [7:0] b);
    int acc;
    bit left, right;
    acc = cyc + 1;
    if ((m_ext || m_brk) && (acc - m_last_acc) > T) begin
      m_ext = 0;
      m_brk = 0;
    end
    m_last_acc = acc;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (!m_ext) begin
        if (b == 8'h1C) m_hl = !m_brk;
        if (b == 8'h23) m_hr = !m_brk;
        if (b == 8'h29) begin
          if (!m_brk && !m_hs) m_gs = !m_gs;
          m_hs = !m_brk;
        end
      end else begin
`ifdef PS2_ARROW_KEYS_EN
        if (b == 8'h6B) m_hla = !m_brk;
        if (b == 8'h74) m_hra = !m_brk;
`endif
      end
      m_last = b;
      m_ext = 0;
      m_brk = 0;
    end
    left  = m_hl | m_hla;
    right = m_hr | m_hra;
    n_ml = left & !right;
    n_mr = right & !left;
    n_gs = m_gs;
    n_last = m_last;
    sch_at = acc + 1;
    sch_valid = 1;
  endtask

  // Every-cycle compare, 1 time unit after the active edge.
  always @(posedge clock) begin
    #1;
    cyc++;
    if (sch_valid && cyc == sch_at) begin
      e_ml = n_ml; e_mr = n_mr; e_gs = n_gs; e_last = n_last;
      sch_valid = 0;
    end
    if (reset) begin
      e_ml = 0; e_mr = 0; e_gs = 0; e_last = 8'h00;
      sch_valid = 0;
      started = 1;
    end
    if (started) begin
      check1("move_left",   bus.move_left,   e_ml);
      check1("move_right",  bus.move_right,  e_mr);
      check1("game_status", bus.game_status, e_gs);
      check8("last_code",   bus.last_code,   e_last);
    end
  end

  // Must be called at a negedge with ps2_key_pressed low on the previous edge.
  task automatic send(input logic [7:0] b, input int hold = 1, input int gap = 2);
    bus.ps2_out = b;
    bus.ps2_key_pressed = 1'b1;
    model_accept(b);
    repeat (hold) @(negedge clock);
    bus.ps2_key_pressed = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic do_reset(input bit with_edge);
    reset = 1'b1;
    if (with_edge) begin
      bus.ps2_out = 8'h1C;
      bus.ps2_key_pressed = 1'b1;
    end else begin
      bus.ps2_key_pressed = 1'b0;
    end
    model_clear();
    @(negedge clock);
    reset = 1'b0;
    bus.ps2_key_pressed = 1'b0;
    @(negedge clock);
  endtask

  logic [7:0] pool [8];

  initial begin
    pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h1C; pool[3] = 8'h23;
    pool[4] = 8'h29; pool[5] = 8'h6B; pool[6] = 8'h74; pool[7] = 8'h5A;
    bus.ps2_key_pressed = 1'b0;
    bus.ps2_out = 8'h00;
    model_clear();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    check1("reset_left", bus.move_left, 1'b0);
    check1("reset_right", bus.move_right, 1'b0);
    check1("reset_status", bus.game_status, 1'b0);
    check8("reset_last", bus.last_code, 8'h00);

    send(8'h1C);
    check1("a_make_left", bus.move_left, 1'b1);
    check1("a_make_right", bus.move_right, 1'b0);
    check8("a_make_last", bus.last_code, 8'h1C);
    send(8'hF0); send(8'h1C);
    check1("a_break_left", bus.move_left, 1'b0);

    send(8'h1C); send(8'h23);
    check1("both_left", bus.move_left, 1'b0);
    check1("both_right", bus.move_right, 1'b0);
    send(8'hF0); send(8'h23);
    check1("d_break_left", bus.move_left, 1'b1);
    check1("d_break_right", bus.move_right, 1'b0);
    send(8'hF0); send(8'h1C);

    send(8'h29);
    check1("space_on", bus.game_status, 1'b1);
    repeat (3) send(8'h29);
    check1("space_repeat", bus.game_status, 1'b1);
    send(8'hF0); send(8'h29);
    check1("space_break", bus.game_status, 1'b1);
    send(8'h29);
    check1("space_off", bus.game_status, 1'b0);

    send(8'hE0); send(8'h1C);
    check1("ext_a_left", bus.move_left, 1'b0);
    check8("ext_a_last", bus.last_code, 8'h1C);
`ifdef PS2_ARROW_KEYS_EN
    send(8'hE0); send(8'h6B);
    check1("larrow_make", bus.move_left, 1'b1);
    send(8'hE0); send(8'hF0); send(8'h6B);
    check1("larrow_break", bus.move_left, 1'b0);
    send(8'h1C); send(8'hE0); send(8'h6B); send(8'hF0); send(8'h1C);
    check1("arrow_keeps_left", bus.move_left, 1'b1);
    send(8'hE0); send(8'hF0); send(8'h6B);
`endif

    send(8'hF0, 1, T + 4); send(8'h23);
    check1("timeout_make", bus.move_right, 1'b1);
    send(8'hF0, 1, T - 1); send(8'h23);
    check1("prefix_at_limit", bus.move_right, 1'b0);
    send(8'h23); send(8'hF0, 1, T); send(8'h23);
    check1("prefix_past_limit", bus.move_right, 1'b1);
    send(8'hF0); send(8'h23);

    send(8'h1C); send(8'hF0); send(8'h1C, 10, 2);
    check1("long_pulse_once", bus.move_left, 1'b0);

    send(8'h1C); send(8'h29); send(8'hF0);
    do_reset(0);
    check1("mid_reset_left", bus.move_left, 1'b0);
    check1("mid_reset_status", bus.game_status, 1'b0);
    check8("mid_reset_last", bus.last_code, 8'h00);
    send(8'h1C);
    check1("post_reset_make", bus.move_left, 1'b1);

    do_reset(1);
    check1("reset_edge_left", bus.move_left, 1'b0);
    check8("reset_edge_last", bus.last_code, 8'h00);

    for (int i = 0; i < 400; i++) begin
      int g;
      logic [7:0] b;
      b = pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) g = $urandom_range(T - 2, T + 2);
      else g = $urandom_range(1, 3);
      if ($urandom_range(0, 49) == 0) do_reset($urandom_range(0, 1) == 1);
      send(b, $urandom_range(1, 3), g);
    end

    repeat (4) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
